// File: rtl/data_xmt_fpga.sv
// Writes a 16-bit result word into the UART transmit FIFO as a byte frame:
// optional header, high byte, low byte, optional XOR checksum of the two data bytes.
module data_xmt_fpga #(
    parameter logic        HDR_EN   = 1'b1,
    parameter logic [7:0]  HDR_BYTE = 8'hA5,
    parameter logic        CHK_EN   = 1'b1,
    parameter int unsigned GAP_CYC  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic [15:0] data_tx,
    input  logic        full_xmt,
    output logic        wr_xmt,
    output logic [7:0]  data_xmt,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state_o
);

    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [1:0] LAST_IDX = 2'(HDR_EN) + 2'(CHK_EN) + 2'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [15:0]   word_q;
    logic [7:0]    chk_q;
    logic [1:0]    idx_q;
    logic [GW-1:0] gap_q;
    logic          wr_q;
    logic [7:0]    data_q;
    logic          busy_q;
    logic          done_q;

    logic [1:0]    slot;
    logic [7:0]    data_d;

    // Without a header the frame index is shifted so slot 1 is always the high byte.
    assign slot = idx_q + {1'b0, ~HDR_EN};

    always_comb begin
        data_d = HDR_BYTE;
        case (slot)
            2'd0:    data_d = HDR_BYTE;
            2'd1:    data_d = word_q[15:8];
            2'd2:    data_d = word_q[7:0];
            default: data_d = chk_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            word_q  <= 16'h0000;
            chk_q   <= 8'h00;
            idx_q   <= 2'd0;
            gap_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wr_q   <= 1'b0;
                    done_q <= 1'b0;
                    // A request landing while the done pulse is still visible is dropped.
                    if (send && !done_q) begin
                        word_q  <= data_tx;
                        chk_q   <= data_tx[15:8] ^ data_tx[7:0];
                        idx_q   <= 2'd0;
                        gap_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!full_xmt && gap_q == '0) begin
                        wr_q   <= 1'b1;
                        data_q <= data_d;
                        idx_q  <= idx_q + 2'd1;
                        gap_q  <= GW'(GAP_CYC);
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_DONE;
                        end
                    end else begin
                        wr_q <= 1'b0;
                        if (gap_q != '0) begin
                            gap_q <= gap_q - GW'(1);
                        end
                    end
                end
                S_DONE: begin
                    wr_q    <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    idx_q   <= 2'd0;
                    state_q <= S_IDLE;
                end
                default: begin
                    wr_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_xmt      = wr_q;
    assign data_xmt    = data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_xmt_fpga.sv
// Bench for data_xmt_fpga: three instances (defaults, bare 2-byte frame, gap of 2) checked
// against an expected byte stream plus directed timing expectations.
module tb_data_xmt_fpga;

    localparam bit HDR_K [3] = '{1'b1, 1'b0, 1'b1};
    localparam bit CHK_K [3] = '{1'b1, 1'b0, 1'b1};
    localparam int GAP_K [3] = '{0, 0, 2};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  send_v = 3'b000;
    logic [2:0]  full_v = 3'b000;
    logic [15:0] dtx [3] = '{16'h0, 16'h0, 16'h0};
    logic [2:0]  wr_v, busy_v, done_v;
    logic [7:0]  dx [3];
    logic [1:0]  st [3];

    always #10 clk = ~clk;

    data_xmt_fpga u_def (
        .clk(clk), .rst(rst), .send(send_v[0]), .data_tx(dtx[0]), .full_xmt(full_v[0]),
        .wr_xmt(wr_v[0]), .data_xmt(dx[0]), .busy(busy_v[0]), .done(done_v[0]),
        .dbg_state_o(st[0])
    );

    data_xmt_fpga #(.HDR_EN(1'b0), .CHK_EN(1'b0)) u_bare (
        .clk(clk), .rst(rst), .send(send_v[1]), .data_tx(dtx[1]), .full_xmt(full_v[1]),
        .wr_xmt(wr_v[1]), .data_xmt(dx[1]), .busy(busy_v[1]), .done(done_v[1]),
        .dbg_state_o(st[1])
    );

    data_xmt_fpga #(.GAP_CYC(2)) u_gap (
        .clk(clk), .rst(rst), .send(send_v[2]), .data_tx(dtx[2]), .full_xmt(full_v[2]),
        .wr_xmt(wr_v[2]), .data_xmt(dx[2]), .busy(busy_v[2]), .done(done_v[2]),
        .dbg_state_o(st[2])
    );

    int checks = 0;
    int failures = 0;

    // Expected stream entries are {instance, byte}.
    logic [9:0] exp_q[$];

    int         st_n[$];
    logic [7:0] st_b[$];
    int         done_n[$];
    logic [63:0] busy_rec;

    int         cyc = 0;
    logic [2:0] full_at_edge = 3'b000;
    int         last_wr [3] = '{-1, -1, -1};

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void push_frame(int k, logic [15:0] d);
        if (HDR_K[k]) exp_q.push_back({2'(k), 8'hA5});
        exp_q.push_back({2'(k), d[15:8]});
        exp_q.push_back({2'(k), d[7:0]});
        if (CHK_K[k]) exp_q.push_back({2'(k), d[15:8] ^ d[7:0]});
    endfunction

    function automatic int pending(int k);
        int c = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i][9:8] == 2'(k)) c++;
        return c;
    endfunction

    function automatic void drop_pending(int k);
        logic [9:0] keep[$];
        for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i][9:8] != 2'(k)) keep.push_back(exp_q[i]);
        exp_q = keep;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        full_at_edge = full_v;
    end

    // Compare process: every strobe must match the next expected byte and obey full/gap rules.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                last_wr[k] = -1;
            end else begin
                if (wr_v[k]) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("spurious_wr%0d", k), 1, 0);
                    end else begin
                        logic [9:0] e;
                        e = exp_q.pop_front();
                        check($sformatf("stream_byte%0d", k), int'({2'(k), dx[k]}), int'(e));
                    end
                    check($sformatf("wr_after_full%0d", k), int'(full_at_edge[k]), 0);
                    check($sformatf("busy_during_wr%0d", k), int'(busy_v[k]), 1);
                    if (last_wr[k] >= 0)
                        check($sformatf("gap_spacing%0d", k),
                              int'(cyc - last_wr[k] >= GAP_K[k] + 1), 1);
                    last_wr[k] = cyc;
                end
                if (done_v[k]) begin
                    check($sformatf("done_bytes_left%0d", k), pending(k), 0);
                    check($sformatf("done_busy%0d", k), int'(busy_v[k]), 0);
                    check($sformatf("done_wr%0d", k), int'(wr_v[k]), 0);
                    last_wr[k] = -1;
                end
            end
        end
    end

    // Issues one send on instance k and records strobes/done/busy for ncyc clocks after acceptance.
    task automatic run_frame(int k, logic [15:0] d, int ncyc, int full_lo, int full_hi,
                             int hold_n, int chg_n, logic [15:0] chg_d, int rst_at);
        st_n.delete();
        st_b.delete();
        done_n.delete();
        busy_rec = '0;
        @(negedge clk);
        #1;
        dtx[k] = d;
        send_v[k] = 1'b1;
        push_frame(k, d);
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            #1;
            if (wr_v[k]) begin
                st_n.push_back(n);
                st_b.push_back(dx[k]);
            end
            if (done_v[k]) done_n.push_back(n);
            busy_rec[n] = busy_v[k];
            send_v[k] = (n < hold_n);
            full_v[k] = (n >= full_lo && n < full_hi);
            if (n == chg_n) dtx[k] = chg_d;
            if (n == rst_at) begin
                rst = 1'b0;
                drop_pending(k);
            end
            if (n == rst_at + 1) rst = 1'b1;
        end
    endtask

    task automatic check_frame(string t, int nb, logic [31:0] pos, logic [31:0] bytes, int exp_done);
        logic [7:0] p, b;
        check({t, "_nstrobes"}, st_n.size(), nb);
        for (int i = 0; i < nb; i++) begin
            p = pos[31 - 8*i -: 8];
            b = bytes[31 - 8*i -: 8];
            if (i < st_n.size()) begin
                check($sformatf("%s_pos%0d", t, i), st_n[i], int'(p));
                check($sformatf("%s_byte%0d", t, i), int'(st_b[i]), int'(b));
            end
        end
        check({t, "_ndone"}, done_n.size(), (exp_done > 0) ? 1 : 0);
        if (exp_done > 0 && done_n.size() > 0)
            check({t, "_done_pos"}, done_n[0], exp_done);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_wr%0d", k), int'(wr_v[k]), 0);
            check($sformatf("rst_busy%0d", k), int'(busy_v[k]), 0);
            check($sformatf("rst_done%0d", k), int'(done_v[k]), 0);
            check($sformatf("rst_data%0d", k), int'(dx[k]), 0);
        end
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // T1: default frame, back-to-back strobes.
        run_frame(0, 16'h1234, 10, 99, 0, 1, 0, 16'h0, 0);
        check_frame("t1", 4, {8'd2, 8'd3, 8'd4, 8'd5}, 32'hA5123426, 6);
        check("t1_busy_n1", int'(busy_rec[1]), 1);
        check("t1_busy_n5", int'(busy_rec[5]), 1);
        check("t1_busy_n6", int'(busy_rec[6]), 0);

        // T2: no header, no checksum.
        run_frame(1, 16'hBEEF, 8, 99, 0, 1, 0, 16'h0, 0);
        check_frame("t2", 2, {8'd2, 8'd3, 16'd0}, {16'hBEEF, 16'h0000}, 4);

        // T3: FIFO full for 5 clocks after the second strobe.
        run_frame(0, 16'h1234, 14, 3, 8, 1, 0, 16'h0, 0);
        check_frame("t3", 4, {8'd2, 8'd3, 8'd9, 8'd10}, 32'hA5123426, 11);

        // T4: two idle clocks between strobes.
        run_frame(2, 16'h00FF, 16, 99, 0, 1, 0, 16'h0, 0);
        check_frame("t4", 4, {8'd2, 8'd5, 8'd8, 8'd11}, 32'hA500FFFF, 12);

        // T5: send held through the frame and data_tx changed mid-frame.
        run_frame(0, 16'h1234, 14, 99, 0, 6, 2, 16'hFFFF, 0);
        check_frame("t5", 4, {8'd2, 8'd3, 8'd4, 8'd5}, 32'hA5123426, 6);
        run_frame(0, 16'h5A3C, 8, 99, 0, 1, 0, 16'h0, 0);
        check_frame("t5b", 4, {8'd2, 8'd3, 8'd4, 8'd5}, 32'hA55A3C66, 6);

        // T6: reset during the second strobe, then a clean frame.
        run_frame(0, 16'h1234, 12, 99, 0, 1, 0, 16'h0, 3);
        check_frame("t6", 2, {8'd2, 8'd3, 16'd0}, {16'hA512, 16'h0000}, 0);
        check("t6_busy_after_rst", int'(busy_rec[4]), 0);
        run_frame(0, 16'h0F0F, 8, 99, 0, 1, 0, 16'h0, 0);
        check_frame("t6b", 4, {8'd2, 8'd3, 8'd4, 8'd5}, 32'hA50F0F00, 6);

        repeat (2) @(negedge clk);
        check("model_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
